// File: rtl/pipe_barrel_shifter.sv
// Pipelined barrel shifter: SLL/SRL/SRA/ROR with one registered stage per shift-amount bit.
// Valid/ready handshake; the whole pipe advances or holds together on a single enable.
module pipe_barrel_shifter #(
  parameter int unsigned WIDTH   = 32,
  parameter int unsigned SHAMT_W = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [WIDTH-1:0]   in_data,
  input  logic [SHAMT_W-1:0] in_shamt,
  input  logic [1:0]         in_op,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [WIDTH-1:0]   out_data,
  output logic               out_zero
);

  localparam int unsigned SHW = $clog2(WIDTH);

  typedef enum logic [1:0] {
    OP_SLL = 2'b00,
    OP_SRL = 2'b01,
    OP_SRA = 2'b10,
    OP_ROR = 2'b11
  } op_e;

  // Fixed-amount shift used by every stage; amt is always a power of two below WIDTH.
  function automatic logic [WIDTH-1:0] step(
    input logic [WIDTH-1:0] d,
    input op_e              op,
    input logic             sign,
    input logic             do_shift,
    input int unsigned      amt
  );
    logic [WIDTH-1:0] fill;
    logic [WIDTH-1:0] res;
    fill = {WIDTH{sign}} << (WIDTH - amt);
    res  = d;
    if (do_shift) begin
      case (op)
        OP_SLL:  res = d << amt;
        OP_SRL:  res = d >> amt;
        OP_SRA:  res = fill | (d >> amt);
        default: res = (d >> amt) | (d << (WIDTH - amt));
      endcase
    end
    return res;
  endfunction

  logic             en;
  logic [SHW-1:0]   valid_q, valid_d;
  logic [WIDTH-1:0] data_q [SHW];
  logic [WIDTH-1:0] data_d [SHW];
  op_e              op_q   [SHW-1];
  op_e              op_d   [SHW-1];
  logic [SHW-2:0]   sign_q, sign_d;
  logic [SHW-1:0]   rem_q  [SHW-1];
  logic [SHW-1:0]   rem_d  [SHW-1];
  logic             zero_q, zero_d;

  op_e              op_in;
  logic             ovr;
  logic [WIDTH-1:0] s0_data;
  logic [SHW-1:0]   s0_rem;

  assign en = !valid_q[SHW-1] || out_ready;

  always_comb begin
    op_in   = op_e'(in_op);
    ovr     = in_shamt >= SHAMT_W'(WIDTH);
    s0_data = in_data;
    s0_rem  = in_shamt[SHW-1:0];
    // Overrange SLL/SRL/SRA is resolved here to its final value; later stages shift by 0.
    if (ovr && op_in != OP_ROR) begin
      s0_rem  = '0;
      s0_data = (op_in == OP_SRA) ? {WIDTH{in_data[WIDTH-1]}} : '0;
    end

    valid_d[0] = in_valid;
    data_d[0]  = step(s0_data, op_in, in_data[WIDTH-1], s0_rem[0], 1);
    op_d[0]    = op_in;
    sign_d[0]  = in_data[WIDTH-1];
    rem_d[0]   = s0_rem >> 1;

    for (int unsigned k = 1; k < SHW; k++) begin
      valid_d[k] = valid_q[k-1];
      data_d[k]  = step(data_q[k-1], op_q[k-1], sign_q[k-1], rem_q[k-1][0], 1 << k);
    end
    for (int unsigned k = 1; k < SHW - 1; k++) begin
      op_d[k]   = op_q[k-1];
      sign_d[k] = sign_q[k-1];
      rem_d[k]  = rem_q[k-1] >> 1;
    end

    zero_d = valid_d[SHW-1] && (data_d[SHW-1] == '0);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid_q <= '0;
      sign_q  <= '0;
      zero_q  <= 1'b0;
      for (int unsigned k = 0; k < SHW; k++) begin
        data_q[k] <= '0;
      end
      for (int unsigned k = 0; k < SHW - 1; k++) begin
        op_q[k]  <= OP_SLL;
        rem_q[k] <= '0;
      end
    end else if (en) begin
      valid_q <= valid_d;
      sign_q  <= sign_d;
      zero_q  <= zero_d;
      for (int unsigned k = 0; k < SHW; k++) begin
        data_q[k] <= data_d[k];
      end
      for (int unsigned k = 0; k < SHW - 1; k++) begin
        op_q[k]  <= op_d[k];
        rem_q[k] <= rem_d[k];
      end
    end
  end

  assign in_ready  = en;
  assign out_valid = valid_q[SHW-1];
  assign out_data  = data_q[SHW-1];
  assign out_zero  = zero_q;

endmodule
